// File: rtl/scan_pkg.sv
// Shared constants and the FSM state type for the decoder scan sequencer.
// NCH   : number of decoder outputs (fixed at 8 for the 3-to-8 decoder)
// SEL_W : width of the channel index driven into the decoder
package scan_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = $clog2(NCH);

  // BLANK is only entered when SCAN_BLANK_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/scan_next_chan.sv
// Combinational next-channel search over a channel mask.
// Ports:
//   mask  [NCH-1:0]   channel enable bits
//   cur   [SEL_W-1:0] current channel; ignored when wrap=1
//   wrap             1 = return the lowest set bit overall
//   nxt   [SEL_W-1:0] lowest set bit above cur (or lowest overall when wrap=1)
//   valid            a qualifying bit was found
module scan_next_chan
  import scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             wrap,
  output logic [SEL_W-1:0] nxt,
  output logic             valid
);

  // Scan from the top down so the lowest qualifying index is written last.
  always_comb begin
    nxt   = '0;
    valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (wrap || (i > int'(cur)))) begin
        nxt   = SEL_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving the sel/en inputs of a 3-to-8 decoder. Steps
// through the channels set in a mask latched at start, holding each for
// DWELL_CYCLES clocks, in single-pass or continuous mode.
// Optional macro SCAN_BLANK_EN: insert a one-cycle en=0 BLANK state on
// every channel change (including wrap) to avoid downstream overlap.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   start scan request, sampled in IDLE only
//   stop  abort, honoured in any non-IDLE state (wins over start)
//   cont  1 = wrap and rescan, 0 = single pass; sampled live
//   mask  [7:0] channel enables, latched on an accepted start
//   sel   [2:0] registered channel index to the decoder
//   en    registered decoder enable
//   busy  high while a scan is in progress
//   done  one-cycle pulse at normal scan completion
module decoder_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [NCH-1:0]   mask,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NCH-1:0]     r_mask, w_mask_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic               r_en, w_en_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  logic [NCH-1:0]     w_low_src;
  logic [SEL_W-1:0]   w_low_chan, w_up_chan, w_tgt;
  logic               w_low_vld, w_up_vld;
  logic               w_last, w_adv, w_accept;

  // In IDLE the first channel comes from the live mask; afterwards the
  // same search provides the wrap target from the latched mask.
  assign w_low_src = (r_state == IDLE) ? mask : r_mask;

  scan_next_chan u_low (
    .mask  (w_low_src),
    .cur   ({SEL_W{1'b0}}),
    .wrap  (1'b1),
    .nxt   (w_low_chan),
    .valid (w_low_vld)
  );

  scan_next_chan u_up (
    .mask  (r_mask),
    .cur   (r_sel),
    .wrap  (1'b0),
    .nxt   (w_up_chan),
    .valid (w_up_vld)
  );

  assign w_accept = start && !stop;
  assign w_last   = (r_cnt == CNT_LAST);
  // Another channel exists either above the current one or via wrap.
  assign w_adv    = w_up_vld || (cont && w_low_vld);
  assign w_tgt    = w_up_vld ? w_up_chan : w_low_chan;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_sel   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
      r_sel   <= w_sel_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = (mask != '0) ? DWELL : DONE;
      end
      DWELL: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          if (!w_adv) w_state_nxt = DONE;
`ifdef SCAN_BLANK_EN
          else if (w_tgt != r_sel) w_state_nxt = BLANK;
`endif
        end
      end
      BLANK:   w_state_nxt = stop ? IDLE : DWELL;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and latched mask
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_mask_nxt = r_mask;
    w_sel_nxt  = r_sel;
    w_en_nxt   = r_en;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_mask_nxt = mask;
          if (mask != '0) begin
            w_sel_nxt  = w_low_chan;
            w_en_nxt   = 1'b1;
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = '0;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      DWELL: begin
        if (stop) begin
          w_en_nxt   = 1'b0;
          w_busy_nxt = 1'b0;
        end else if (w_last) begin
          w_cnt_nxt = '0;
          if (!w_adv) begin
            w_en_nxt   = 1'b0;
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
          end else begin
            w_sel_nxt = w_tgt;
`ifdef SCAN_BLANK_EN
            // A single-channel wrap is not a change, so en stays high.
            if (w_tgt != r_sel) w_en_nxt = 1'b0;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      BLANK: begin
        if (stop) begin
          w_en_nxt   = 1'b0;
          w_busy_nxt = 1'b0;
        end else begin
          w_en_nxt = 1'b1;
        end
      end
      DONE: begin
        w_en_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
      end
      default: begin
        w_en_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign sel  = r_sel;
  assign en   = r_en;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
module tb_decoder_scan_sequencer;

  localparam int DW = 4;

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, cont;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       en, busy, done;

  obs_t       q[$];
  int         chq[$];
  logic [2:0] m_sel;
  int         checks = 0;
  int         errors = 0;

  decoder_scan_sequencer #(.DWELL_CYCLES(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .cont  (cont),
    .mask  (mask),
    .sel   (sel),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [2:0] s, input logic e, input logic b, input logic d);
    obs_t o;
    o.sel  = s;
    o.en   = e;
    o.busy = b;
    o.done = d;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected observations for a scan over the channels in chq, ending in done.
  task automatic push_chans();
    int prev;
    prev = -1;
    foreach (chq[k]) begin
`ifdef SCAN_BLANK_EN
      if (k > 0 && chq[k] != prev) q.push_back(mk(3'(chq[k]), 1'b0, 1'b1, 1'b0));
`endif
      repeat (DW) q.push_back(mk(3'(chq[k]), 1'b1, 1'b1, 1'b0));
      prev = chq[k];
    end
    m_sel = 3'(prev);
    q.push_back(mk(m_sel, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic start_scan(input logic [7:0] m, input logic c);
    @(negedge clk);
    mask  = m;
    cont  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, q.size(), 0);
    q.delete();
    repeat (2) @(negedge clk);
    check({name, "_idle_en"}, en, 0);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_done"}, done, 0);
  endtask

  // Monitor: every cycle presenting activity must match the next expectation.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (!rst && (busy || done || en)) begin
        a = mk(sel, en, busy, done);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h expected=none at %0t", a, $time);
        end else begin
          e = q.pop_front();
          check("obs", a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    cont  = 1'b0;
    mask  = 8'h00;
    m_sel = 3'd0;
    #1;
    check("rst_sel", sel, 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full mask, single pass
    chq = '{0, 1, 2, 3, 4, 5, 6, 7};
    push_chans();
    start_scan(8'hFF, 1'b0);
    drain("full", 80);

    // Sparse mask; start with a different mask mid-scan is ignored
    chq = '{2, 5, 7};
    push_chans();
    start_scan(8'b1010_0100, 1'b0);
    repeat (5) @(negedge clk);
    mask  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mask  = 8'b1010_0100;
    drain("sparse", 40);

    // Empty mask: immediate done, en/busy never rise
    q.push_back(mk(m_sel, 1'b0, 1'b0, 1'b1));
    start_scan(8'h00, 1'b0);
    drain("empty", 10);

    // Continuous wrap 0,7,0,7 then cont dropped during second sel=7
    chq = '{0, 7, 0, 7};
    push_chans();
    start_scan(8'h81, 1'b1);
`ifdef SCAN_BLANK_EN
    repeat (16) @(negedge clk);
`else
    repeat (13) @(negedge clk);
`endif
    cont = 1'b0;
    drain("wrap", 40);

    // Stop on the second dwell cycle of sel=3
    q.push_back(mk(3'd3, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(3'd3, 1'b1, 1'b1, 1'b0));
    start_scan(8'h18, 1'b0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_en", en, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    check("stop_sel", sel, 3);
    m_sel = 3'd3;
    drain("stop", 10);

    // Start together with stop in IDLE: stop wins
    @(negedge clk);
    mask  = 8'hFF;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_en", en, 0);
    drain("startstop", 4);

    // Lower nibble (blank pattern when the feature is built in)
    chq = '{0, 1, 2, 3};
    push_chans();
    start_scan(8'h0F, 1'b0);
    drain("nibble", 40);

    // Asynchronous reset mid-dwell
    repeat (3) q.push_back(mk(3'd0, 1'b1, 1'b1, 1'b0));
    start_scan(8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sel", sel, 0);
    check("arst_en", en, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    m_sel = 3'd0;
    drain("arst", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
